// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment display controller.
// Holds one hex value and decimal point per digit, scans the digits onto
// active-low anode enables and segment lines, with hex glyphs, per-digit
// blanking, leading-zero suppression, PWM brightness, blink and a frame strobe.
//
// Ports:
//   clk          system clock, rising edge
//   button1      asynchronous active-high reset
//   wr_en        write strobe (one digit per cycle)
//   wr_addr      digit index to write; indices >= DIGITS are ignored
//   wr_data      hex value for that digit
//   wr_dp        decimal point for that digit (1 = lit)
//   blank_mask   bit i forces digit i dark
//   blink_mask   bit i makes digit i blink
//   lz_suppress  leading-zero suppression enable
//   bright       on-time in eighths of a slot (bright+1)/8
//   en           anode enables, active-low, bit i = digit i
//   cx           segments, active-low, cx[7:1] = a..g, cx[0] = dp
//   frame        one-cycle pulse per completed scan
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 200000,
    parameter int BLINK_FRAMES = 64,
    parameter int AW           = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              button1,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    input  logic [DIGITS-1:0] blank_mask,
    input  logic [DIGITS-1:0] blink_mask,
    input  logic              lz_suppress,
    input  logic [2:0]        bright,
    output logic [DIGITS-1:0] en,
    output logic [7:0]        cx,
    output logic              frame
);

    localparam int SUB = CLK_DIV / 8;
    localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0]     SUB_TOP = SW'(SUB - 1);
    localparam logic [FW-1:0]     FR_TOP  = FW'(BLINK_FRAMES - 1);
    localparam logic [AW-1:0]     SEL_TOP = AW'(DIGITS - 1);
    localparam logic [AW:0]       NDIG    = (AW + 1)'(DIGITS);
    localparam logic [DIGITS-1:0] DIG0    = DIGITS'(1);

    logic [3:0]        val_q [DIGITS];
    logic [DIGITS-1:0] dp_q;

    // Sub-phase and frame counters count down to a terminal count of zero;
    // only their period is visible outside.
    logic [SW-1:0]     sub_q;
    logic [2:0]        ph_q;
    logic [AW-1:0]     sel_q;
    logic [FW-1:0]     fcnt_q;
    logic              blink_q;

    logic [DIGITS-1:0] en_q, en_d;
    logic [7:0]        cx_q, cx_d;
    logic              frame_q;

    logic              sub_tc, slot_end, wrap;
    logic [DIGITS-1:0] supp;
    logic [7:0]        glyph;
    logic              dark;

    function automatic logic [7:0] seg_lut(input logic [3:0] v);
        case (v)
            4'h0: seg_lut = 8'h03;
            4'h1: seg_lut = 8'h9F;
            4'h2: seg_lut = 8'h25;
            4'h3: seg_lut = 8'h0D;
            4'h4: seg_lut = 8'h99;
            4'h5: seg_lut = 8'h49;
            4'h6: seg_lut = 8'h41;
            4'h7: seg_lut = 8'h1F;
            4'h8: seg_lut = 8'h01;
            4'h9: seg_lut = 8'h19;
            4'hA: seg_lut = 8'h11;
            4'hB: seg_lut = 8'hC1;
            4'hC: seg_lut = 8'h63;
            4'hD: seg_lut = 8'h85;
            4'hE: seg_lut = 8'h61;
            default: seg_lut = 8'h71;
        endcase
    endfunction

    assign sub_tc   = (sub_q == '0);
    assign slot_end = sub_tc && (ph_q == 3'd7);
    assign wrap     = slot_end && (sel_q == '0);

    always_ff @(posedge clk or posedge button1) begin
        if (button1) begin
            for (int i = 0; i < DIGITS; i++) begin
                val_q[i] <= '0;
            end
            dp_q <= '0;
        end else if (wr_en && ({1'b0, wr_addr} < NDIG)) begin
            val_q[wr_addr] <= wr_data;
            dp_q[wr_addr]  <= wr_dp;
        end
    end

    always_ff @(posedge clk or posedge button1) begin
        if (button1) begin
            sub_q   <= SUB_TOP;
            ph_q    <= '0;
            sel_q   <= SEL_TOP;
            fcnt_q  <= FR_TOP;
            blink_q <= 1'b0;
        end else begin
            sub_q <= sub_tc ? SUB_TOP : sub_q - SW'(1);
            if (sub_tc) begin
                ph_q <= ph_q + 3'd1;
            end
            if (slot_end) begin
                sel_q <= (sel_q == '0) ? SEL_TOP : sel_q - AW'(1);
            end
            if (wrap) begin
                if (fcnt_q == '0) begin
                    fcnt_q  <= FR_TOP;
                    blink_q <= ~blink_q;
                end else begin
                    fcnt_q <= fcnt_q - FW'(1);
                end
            end
        end
    end

    // A digit is suppressed when it and every digit to its left hold zero;
    // a lit dp keeps the digit itself visible. Digit 0 always shows.
    always_comb begin : lz_chain
        logic hz;
        supp = '0;
        hz   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            supp[i] = lz_suppress & hz & (val_q[i] == 4'h0) & ~dp_q[i];
            hz      = hz & (val_q[i] == 4'h0);
        end
    end

    // en and cx come from one next-state so anode and glyph switch together.
    always_comb begin
        glyph = seg_lut(val_q[sel_q]);
        if (dp_q[sel_q]) begin
            glyph[0] = 1'b0;
        end
        dark = blank_mask[sel_q] | (blink_mask[sel_q] & blink_q) | supp[sel_q];
        en_d = '1;
        cx_d = 8'hFF;
        if (ph_q <= bright) begin
            en_d = ~(DIG0 << sel_q);
            if (!dark) begin
                cx_d = glyph;
            end
        end
    end

    always_ff @(posedge clk or posedge button1) begin
        if (button1) begin
            en_q    <= '1;
            cx_q    <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            cx_q    <= cx_d;
            frame_q <= wrap;
        end
    end

    assign en    = en_q;
    assign cx    = cx_q;
    assign frame = frame_q;

endmodule
